// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU scan-out path: VGA 640x480@60 timing,
// NES frame geometry and video-buffer address width.
package ppu_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int NES_W   = 256;
  localparam int NES_H   = 240;
  localparam int VBUF_AW = 17;

  localparam logic [5:0] BLACK_IDX = 6'h0F;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_sync_t;

  localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

endpackage

// File: rtl/ppu_ntsc_pal.sv
// 64-entry NES colour-index to 12-bit RGB ROM with a registered output,
// advancing only on the pixel clock enable.
module ppu_ntsc_pal (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic [5:0]  i_idx,
  output logic [11:0] o_rgb
);

  localparam logic [11:0] PAL [64] = '{
    12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
    12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
    12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
    12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
    12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
    12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
    12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
  };

  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = i_ce ? PAL[i_idx] : rgb_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign o_rgb = rgb_q;

endmodule

// File: rtl/ppu_vscan.sv
// VGA scan-out of the double-banked NES frame buffer (2x scaled, centred) with
// tear-free bank swap. Define PPU_VSCAN_SCANLINE_EN to dim odd lines.
module ppu_vscan
  import ppu_pkg::*;
#(
  parameter int H_BORDER = 64
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_ce,
  input  logic               i_frame_done,
  output logic               o_wr_bank,
  output logic [VBUF_AW-1:0] o_vbuf_addr,
  output logic               o_vbuf_re,
  input  logic [7:0]         i_vbuf_rdata,
  output logic               o_vga_hs,
  output logic               o_vga_vs,
  output logic               o_vga_de,
  output logic [3:0]         o_vga_r,
  output logic [3:0]         o_vga_g,
  output logic [3:0]         o_vga_b
);

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_WIN_LO  = 10'(H_BORDER);
  localparam logic [9:0] H_WIN_HI  = 10'(H_BORDER + 2 * NES_W);

  logic [9:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic               rd_bank_q, rd_bank_d, pending_q, pending_d;
  logic [VBUF_AW-1:0] vbuf_addr_q, vbuf_addr_d;
  logic               vbuf_re_q, vbuf_re_d, win2_q, win2_d;
  vga_sync_t          sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic               in_win, rdata_unused;
  logic [7:0]         win_x;
  logic [5:0]         pal_idx;
  logic [11:0]        pal_rgb, rgb_out;

  assign in_win = (hcnt_q >= H_WIN_LO) && (hcnt_q < H_WIN_HI) && (vcnt_q < V_ACT);
  assign win_x  = 8'((hcnt_q - H_WIN_LO) >> 1);

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    rd_bank_d   = rd_bank_q;
    pending_d   = pending_q;
    vbuf_addr_d = vbuf_addr_q;
    vbuf_re_d   = vbuf_re_q;
    win2_d      = win2_q;
    sync1_d     = sync1_q;
    sync2_d     = sync2_q;
    sync3_d     = sync3_q;
    if (i_pix_ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      vbuf_re_d   = in_win;
      vbuf_addr_d = in_win ? {rd_bank_q, vcnt_q[8:1], win_x} : '0;
      sync1_d.hs  = ~((hcnt_q >= H_SYNC_LO) && (hcnt_q < H_SYNC_HI));
      sync1_d.vs  = ~((vcnt_q >= V_SYNC_LO) && (vcnt_q < V_SYNC_HI));
      sync1_d.de  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      win2_d      = vbuf_re_q;
      sync2_d     = sync1_q;
      sync3_d     = sync2_q;
    end
    // A frame_done pulse may land between strobes, so it is captured on any cycle.
    if (i_pix_ce && (hcnt_q == '0) && (vcnt_q == V_ACT) && (pending_q || i_frame_done)) begin
      rd_bank_d = ~rd_bank_q;
      pending_d = 1'b0;
    end else if (i_frame_done) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      rd_bank_q   <= 1'b0;
      pending_q   <= 1'b0;
      vbuf_addr_q <= '0;
      vbuf_re_q   <= 1'b0;
      win2_q      <= 1'b0;
      sync1_q     <= SYNC_IDLE;
      sync2_q     <= SYNC_IDLE;
      sync3_q     <= SYNC_IDLE;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      rd_bank_q   <= rd_bank_d;
      pending_q   <= pending_d;
      vbuf_addr_q <= vbuf_addr_d;
      vbuf_re_q   <= vbuf_re_d;
      win2_q      <= win2_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
    end
  end

  assign pal_idx      = win2_q ? i_vbuf_rdata[5:0] : BLACK_IDX;
  assign rdata_unused = ^i_vbuf_rdata[7:6];

  ppu_ntsc_pal u_pal (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ce  (i_pix_ce),
    .i_idx (pal_idx),
    .o_rgb (pal_rgb)
  );

`ifdef PPU_VSCAN_SCANLINE_EN
  logic odd1_q, odd1_d, odd2_q, odd2_d, odd3_q, odd3_d;

  always_comb begin
    odd1_d = odd1_q;
    odd2_d = odd2_q;
    odd3_d = odd3_q;
    if (i_pix_ce) begin
      odd1_d = vcnt_q[0];
      odd2_d = odd1_q;
      odd3_d = odd2_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      odd1_q <= 1'b0;
      odd2_q <= 1'b0;
      odd3_q <= 1'b0;
    end else begin
      odd1_q <= odd1_d;
      odd2_q <= odd2_d;
      odd3_q <= odd3_d;
    end
  end
`endif

  always_comb begin
    rgb_out = sync3_q.de ? pal_rgb : '0;
`ifdef PPU_VSCAN_SCANLINE_EN
    if (odd3_q) rgb_out = {1'b0, rgb_out[11:9], 1'b0, rgb_out[7:5], 1'b0, rgb_out[3:1]};
`endif
  end

  assign o_wr_bank = ~rd_bank_q;
  assign o_vbuf_addr = vbuf_addr_q;
  assign o_vbuf_re   = vbuf_re_q;
  assign o_vga_hs    = sync3_q.hs;
  assign o_vga_vs    = sync3_q.vs;
  assign o_vga_de    = sync3_q.de;
  assign {o_vga_r, o_vga_g, o_vga_b} = rgb_out;

endmodule

// File: tb/tb_ppu_vscan.sv
// Randomised bench for ppu_vscan: a frame-level reference model (pixel queue,
// palette table, bank/pending flags) predicts every output on every cycle.
module tb_ppu_vscan;
  import ppu_pkg::*;

  localparam int HB = 64;

  logic               clk = 1'b0;
  logic               rst, pix_ce, frame_done;
  logic               wr_bank, vbuf_re, vga_hs, vga_vs, vga_de;
  logic [16:0]        vbuf_addr;
  logic [7:0]         vbuf_rdata = 8'h00;
  logic [3:0]         vga_r, vga_g, vga_b;

  always #5 clk = ~clk;

  ppu_vscan #(.H_BORDER(HB)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pix_ce     (pix_ce),
    .i_frame_done (frame_done),
    .o_wr_bank    (wr_bank),
    .o_vbuf_addr  (vbuf_addr),
    .o_vbuf_re    (vbuf_re),
    .i_vbuf_rdata (vbuf_rdata),
    .o_vga_hs     (vga_hs),
    .o_vga_vs     (vga_vs),
    .o_vga_de     (vga_de),
    .o_vga_r      (vga_r),
    .o_vga_g      (vga_g),
    .o_vga_b      (vga_b)
  );

  logic [7:0]  mem [0:131071];
  logic [11:0] pal [0:63];

  // Synchronous video-buffer RAM: data appears one strobe after the read.
  always @(posedge clk) if (pix_ce && vbuf_re) vbuf_rdata <= mem[vbuf_addr];

  typedef struct {
    logic [14:0] vga;
    logic [17:0] vbuf;
    int          h;
    int          v;
    int          f;
    logic        bank;
  } rec_t;

  rec_t        q[$];
  int          mh = 0, mv = 0, mf = 0;
  logic        mbank = 1'b0, mpend = 1'b0;
  logic [14:0] exp_vga;
  logic [17:0] exp_vbuf;
  logic        exp_wr;
  int          n_checks = 0, n_fail = 0;
  int          swap_idx = 0, cur_f = -1;
  int          cnt_px = 0, cnt_de = 0, cnt_hs = 0, cnt_vs = 0;
  logic        swap_exp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

`ifdef PPU_VSCAN_SCANLINE_EN
  localparam logic [11:0] SCAN_ODD_EXP = 12'h752;
`else
  localparam logic [11:0] SCAN_ODD_EXP = 12'hFA4;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rec_t makeRec(input int h, input int v, input logic bank);
    rec_t        r;
    logic        win, de, hs, vs;
    logic [16:0] a;
    logic [5:0]  idx;
    logic [11:0] c;
    win = (h >= HB) && (h < HB + 512) && (v < 480);
    a   = win ? {bank, 8'(v / 2), 8'((h - HB) / 2)} : 17'h0;
    idx = win ? mem[a][5:0] : 6'h0F;
    de  = (h < 640) && (v < 480);
    c   = de ? pal[idx] : 12'h000;
`ifdef PPU_VSCAN_SCANLINE_EN
    if (v % 2 == 1) c = {4'(c[11:8] / 2), 4'(c[7:4] / 2), 4'(c[3:0] / 2)};
`endif
    hs = !((h >= 656) && (h < 752));
    vs = !((v >= 490) && (v < 492));
    r.vga  = {hs, vs, de, c};
    r.vbuf = {win, a};
    r.h = h; r.v = v; r.f = mf; r.bank = bank;
    return r;
  endfunction

  task automatic frameTally(input rec_t r);
    if (r.f != cur_f) begin
      if (cur_f >= 0 && cur_f <= 3) begin
        checkOutput("frame_strobes", 32'(cnt_px), 32'd420000);
        checkOutput("frame_de",      32'(cnt_de), 32'd307200);
        checkOutput("frame_hs_low",  32'(cnt_hs), 32'd50400);
        checkOutput("frame_vs_low",  32'(cnt_vs), 32'd1600);
      end
      cur_f = r.f;
      cnt_px = 0; cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    end
    cnt_px++;
    if (vga_de)  cnt_de++;
    if (!vga_hs) cnt_hs++;
    if (!vga_vs) cnt_vs++;
  endtask

  task automatic applyStimulus(input logic r, input logic ce, input logic fd);
    rec_t pre, out_rec;
    logic popped, at_swap;
    popped = 1'b0; at_swap = 1'b0;
    rst = r; pix_ce = ce; frame_done = fd;
    if (r) begin
      mf = (mf == 4) ? 9 : 0;
      mh = 0; mv = 0; mbank = 1'b0; mpend = 1'b0;
      q.delete();
      exp_vga = {3'b110, 12'h000}; exp_vbuf = '0; exp_wr = 1'b1;
    end else if (ce) begin
      pre = makeRec(mh, mv, mbank);
      q.push_back(pre);
      exp_vbuf = pre.vbuf;
      at_swap = (mh == 0) && (mv == 480);
      if (at_swap && (mpend || fd)) begin
        mbank = ~mbank; mpend = 1'b0;
      end else if (fd) begin
        mpend = 1'b1;
      end
      mh++;
      if (mh == 800) begin
        mh = 0; mv++;
        if (mv == 525) begin mv = 0; mf++; end
      end
      if (q.size() == 3) begin
        out_rec = q.pop_front(); exp_vga = out_rec.vga; popped = 1'b1;
      end
      exp_wr = ~mbank;
    end else if (fd) begin
      mpend = 1'b1;
    end
    @(negedge clk);
    checkOutput("vga", 32'({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b}), 32'(exp_vga));
    checkOutput("vbuf", 32'({vbuf_re, vbuf_addr}), 32'(exp_vbuf));
    checkOutput("wr_bank", 32'(wr_bank), 32'(exp_wr));
    if (!r && ce) begin
      if (pre.h == HB && pre.v == 0 && !pre.bank)
        checkOutput("addr_first", 32'({vbuf_re, vbuf_addr}), 32'h20000);
      if (pre.h == HB + 511 && pre.v == 479 && !pre.bank)
        checkOutput("addr_last", 32'({vbuf_re, vbuf_addr}), 32'h2EFFF);
      if (pre.h == HB - 1 || pre.h == HB + 512)
        checkOutput("re_edge", 32'(vbuf_re), 32'd0);
    end
    if (popped) begin
      frameTally(out_rec);
      if (out_rec.h == HB + 10 && out_rec.v == 20 && !out_rec.bank)
        checkOutput("pix_c1", 32'({vga_r, vga_g, vga_b}), 32'h00F);
      if (out_rec.h == HB && out_rec.v == 3 && !out_rec.bank)
        checkOutput("scan_odd", 32'({vga_r, vga_g, vga_b}), 32'(SCAN_ODD_EXP));
      if (out_rec.h == HB && out_rec.v == 4 && !out_rec.bank)
        checkOutput("scan_even", 32'({vga_r, vga_g, vga_b}), 32'hFA4);
      if (out_rec.h == HB - 1 && out_rec.v < 480)
        checkOutput("border", 32'({vga_r, vga_g, vga_b}), 32'h000);
    end
    if (at_swap && swap_idx < 5) begin
      checkOutput("swap_wr_bank", 32'(wr_bank), 32'(swap_exp[swap_idx]));
      swap_idx++;
    end
  endtask

  initial begin
    logic r, ce, fd, done;
    int   cyc;
    pal = '{
      12'h777, 12'h00F, 12'h00B, 12'h42B, 12'h908, 12'hA02, 12'hA10, 12'h810,
      12'h530, 12'h070, 12'h060, 12'h050, 12'h045, 12'h000, 12'h000, 12'h000,
      12'hBBB, 12'h07F, 12'h05F, 12'h64F, 12'hD0C, 12'hE05, 12'hF30, 12'hE51,
      12'hA70, 12'h0B0, 12'h0A0, 12'h0A4, 12'h088, 12'h000, 12'h000, 12'h000,
      12'hFFF, 12'h3BF, 12'h68F, 12'h97F, 12'hF7F, 12'hF59, 12'hF75, 12'hFA4,
      12'hFB0, 12'hBF1, 12'h5D5, 12'h5F9, 12'h0ED, 12'h777, 12'h000, 12'h000,
      12'hFFF, 12'hAEF, 12'hBBF, 12'hDBF, 12'hFBF, 12'hFAC, 12'hFDB, 12'hFEA,
      12'hFD7, 12'hDF7, 12'hBFB, 12'hBFD, 12'h0FF, 12'hFDF, 12'h000, 12'h000
    };
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[{1'b0, 8'd10, 8'd5}] = 8'hC1;
    mem[{1'b0, 8'd1, 8'd0}]  = 8'h27;
    mem[{1'b0, 8'd2, 8'd0}]  = 8'h27;

    $display("[TB] ppu_vscan: reset, then swap scenarios over several frames");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);

    done = 1'b0;
    cyc  = 0;
    while (!done && n_fail < 50 && cyc < 3000000) begin
      r  = (mf == 4) && (mv == 200) && (mh == 0);
      if (r)                        ce = 1'b0;
      else if (mf == 0 && mv < 24)  ce = (cyc % 4 == 0);
      else if (mf == 1 && mv < 8)   ce = ($urandom_range(0, 2) == 0);
      else                          ce = 1'b1;
      fd = ce && ((mf == 0 && mh == 300 && (mv == 100 || mv == 200)) ||
                  (mf == 2 && mh == 0 && mv == 480) ||
                  (mf == 4 && mh == 300 && mv == 100));
      applyStimulus(r, ce, fd);
      cyc++;
      done = (mf == 9) && (mv == 495);
    end
    checkOutput("run_complete", 32'(done), 32'd1);
    checkOutput("swap_points_seen", 32'(swap_idx), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
